// File: rtl/invaders_pkg.sv
// Shared types and helpers for the invader-grid collision logic.
package invaders_pkg;

    typedef logic [11:0] coord_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        CHECK = 2'd2
    } collision_state_t;

    // Row 0 (top) is worth the most; each row further down is worth one base step less.
    function automatic int unsigned points(input int unsigned row,
                                           input int unsigned num_rows,
                                           input int unsigned base);
        return base * (num_rows - row);
    endfunction

endpackage

// File: rtl/aabb_overlap.sv
// Inclusive axis-aligned box overlap test between box A (invader) and box B (bullet).
module aabb_overlap #(
    parameter int unsigned A_W = 64,
    parameter int unsigned A_H = 32,
    parameter int unsigned B_W = 16,
    parameter int unsigned B_H = 32
) (
    input  logic [12:0] a_x_i,
    input  logic [12:0] a_y_i,
    input  logic [12:0] b_x_i,
    input  logic [12:0] b_y_i,
    output logic        hit_o
);

    // 13-bit operands keep every sum free of wrap for 12-bit coordinates.
    always_comb begin
        hit_o = (b_x_i <= a_x_i + 13'(A_W)) && (b_x_i + 13'(B_W) >= a_x_i) &&
                (b_y_i <= a_y_i + 13'(A_H)) && (b_y_i + 13'(B_H) >= a_y_i);
    end

endmodule

// File: rtl/collision_engine.sv
// Frame-synchronous collision controller: snapshots positions on frame_start, scans the
// invader grid one cell per clock against all bullets, and owns alive/score/invasion state.
module collision_engine
    import invaders_pkg::*;
#(
    parameter int unsigned NUM_INVADERS = 10,
    parameter int unsigned NUM_ROWS     = 3,
    parameter int unsigned NUM_BULLETS  = 4,
    parameter int unsigned ROW_PITCH    = 100,
    parameter int unsigned INVADER_W    = 64,
    parameter int unsigned INVADER_H    = 32,
    parameter int unsigned BULLET_W     = 16,
    parameter int unsigned BULLET_H     = 32,
    parameter int unsigned INVASION_Y   = 568,
    parameter int unsigned POINTS_BASE  = 10,
    parameter int unsigned SCORE_W      = 16,
    localparam int RW    = $clog2(NUM_ROWS),
    localparam int CW    = $clog2(NUM_INVADERS),
    localparam int AC_W  = $clog2(NUM_ROWS * NUM_INVADERS + 1)
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      frame_start,
    input  logic                                      wave_reset,
    input  logic [NUM_BULLETS-1:0][11:0]              bullet_x,
    input  logic [NUM_BULLETS-1:0][11:0]              bullet_y,
    input  logic [NUM_BULLETS-1:0]                    bullet_active,
    input  logic [NUM_INVADERS-1:0][11:0]             invader_x,
    input  logic [9:0]                                enemy_ypos,
    output logic [NUM_ROWS-1:0][NUM_INVADERS-1:0]     alive,
    output logic [NUM_BULLETS-1:0]                    bullet_hit,
    output logic                                      kill_valid,
    output logic [RW-1:0]                             kill_row,
    output logic [CW-1:0]                             kill_col,
    output logic [SCORE_W-1:0]                        score,
    output logic [AC_W-1:0]                           alive_count,
    output logic                                      wave_cleared,
    output logic                                      player_hit,
    output logic                                      busy,
    output logic                                      overrun
);

    localparam int unsigned TOTAL = NUM_ROWS * NUM_INVADERS;

    collision_state_t                         state_q;
    logic [RW-1:0]                            row_q;
    logic [CW-1:0]                            col_q;
    coord_t [NUM_BULLETS-1:0]                 snap_bx_q;
    coord_t [NUM_BULLETS-1:0]                 snap_by_q;
    logic [NUM_BULLETS-1:0]                   snap_act_q;
    coord_t [NUM_INVADERS-1:0]                snap_ix_q;
    logic [9:0]                               snap_y_q;
    logic [NUM_BULLETS-1:0]                   used_q;
    logic [NUM_ROWS-1:0][NUM_INVADERS-1:0]    alive_q;
    logic [AC_W-1:0]                          count_q;
    logic [SCORE_W-1:0]                       score_q;
    logic                                     kv_q;
    logic [RW-1:0]                            krow_q;
    logic [CW-1:0]                            kcol_q;
    logic [NUM_BULLETS-1:0]                   bh_q;
    logic                                     ph_q;
    logic                                     ovr_q;
    logic                                     busy_q;

    logic [12:0]                              cell_x_s;
    logic [12:0]                              cell_y_s;
    logic [NUM_BULLETS-1:0]                   hit_s;
    logic [NUM_BULLETS-1:0]                   cand_s;
    logic [NUM_BULLETS-1:0]                   win_s;
    logic                                     kill_s;
    logic                                     last_cell_s;
    logic [SCORE_W:0]                         score_sum_s;
    logic [SCORE_W-1:0]                       score_d;
    logic [RW:0]                              live_s;
    logic [12:0]                              bottom_s;

    // Bottom-most row holding any live invader; MSB flags that such a row exists.
    function automatic logic [RW:0] lowest_live_row(
        input logic [NUM_ROWS-1:0][NUM_INVADERS-1:0] mask);
        logic [RW:0] r;
        r = '0;
        for (int i = 0; i < int'(NUM_ROWS); i++) begin
            r = (|mask[i]) ? {1'b1, RW'(i)} : r;
        end
        return r;
    endfunction

    // Geometry of the cell currently under test, taken from the frame snapshot.
    always_comb begin
        cell_x_s = {1'b0, snap_ix_q[col_q]};
        cell_y_s = 13'(snap_y_q) + 13'(row_q) * 13'(ROW_PITCH);
    end

    for (genvar b = 0; b < int'(NUM_BULLETS); b++) begin : g_aabb
        aabb_overlap #(
            .A_W(INVADER_W), .A_H(INVADER_H), .B_W(BULLET_W), .B_H(BULLET_H)
        ) u_aabb (
            .a_x_i(cell_x_s),
            .a_y_i(cell_y_s),
            .b_x_i({1'b0, snap_bx_q[b]}),
            .b_y_i({1'b0, snap_by_q[b]}),
            .hit_o(hit_s[b])
        );
    end

    // Kill arbitration: lowest-index eligible bullet wins a live cell; score saturates.
    always_comb begin
        cand_s      = hit_s & snap_act_q & ~used_q & {NUM_BULLETS{alive_q[row_q][col_q]}};
        win_s       = cand_s & (~cand_s + NUM_BULLETS'(1));
        kill_s      = |cand_s;
        last_cell_s = (row_q == RW'(NUM_ROWS - 1)) && (col_q == CW'(NUM_INVADERS - 1));
        score_sum_s = {1'b0, score_q} +
                      (SCORE_W+1)'(points(32'(row_q), NUM_ROWS, POINTS_BASE));
        score_d     = score_sum_s[SCORE_W] ? '1 : score_sum_s[SCORE_W-1:0];
        live_s      = lowest_live_row(alive_q);
        bottom_s    = 13'(snap_y_q) + 13'(live_s[RW-1:0]) * 13'(ROW_PITCH) + 13'(INVADER_H);
    end

    // Scan controller and all registered game state.
    always_ff @(posedge clk) begin
        kv_q <= 1'b0;
        bh_q <= '0;
        if (rst) begin
            state_q    <= IDLE;
            row_q      <= '0;
            col_q      <= '0;
            snap_bx_q  <= '0;
            snap_by_q  <= '0;
            snap_act_q <= '0;
            snap_ix_q  <= '0;
            snap_y_q   <= '0;
            used_q     <= '0;
            alive_q    <= '1;
            count_q    <= AC_W'(TOTAL);
            score_q    <= '0;
            krow_q     <= '0;
            kcol_q     <= '0;
            ph_q       <= 1'b0;
            ovr_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else if (wave_reset) begin
            // Abort any scan; score and the overrun history survive a new wave.
            state_q <= IDLE;
            busy_q  <= 1'b0;
            alive_q <= '1;
            count_q <= AC_W'(TOTAL);
            ph_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (frame_start) begin
                        snap_bx_q  <= bullet_x;
                        snap_by_q  <= bullet_y;
                        snap_act_q <= bullet_active;
                        snap_ix_q  <= invader_x;
                        snap_y_q   <= enemy_ypos;
                        used_q     <= '0;
                        row_q      <= '0;
                        col_q      <= '0;
                        state_q    <= SCAN;
                        busy_q     <= 1'b1;
                    end else begin
                        busy_q <= 1'b0;
                    end
                end
                SCAN: begin
                    if (frame_start) begin
                        ovr_q <= 1'b1;
                    end
                    if (kill_s) begin
                        alive_q[row_q][col_q] <= 1'b0;
                        count_q <= count_q - AC_W'(1);
                        score_q <= score_d;
                        kv_q    <= 1'b1;
                        krow_q  <= row_q;
                        kcol_q  <= col_q;
                        bh_q    <= win_s;
                        used_q  <= used_q | win_s;
                    end
                    if (last_cell_s) begin
                        state_q <= CHECK;
                    end else if (col_q == CW'(NUM_INVADERS - 1)) begin
                        col_q <= '0;
                        row_q <= row_q + RW'(1);
                    end else begin
                        col_q <= col_q + CW'(1);
                    end
                end
                CHECK: begin
                    if (frame_start) begin
                        ovr_q <= 1'b1;
                    end
                    if (live_s[RW] && (bottom_s >= 13'(INVASION_Y))) begin
                        ph_q <= 1'b1;
                    end
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign alive        = alive_q;
    assign bullet_hit   = bh_q;
    assign kill_valid   = kv_q;
    assign kill_row     = krow_q;
    assign kill_col     = kcol_q;
    assign score        = score_q;
    assign alive_count  = count_q;
    assign wave_cleared = (count_q == '0);
    assign player_hit   = ph_q;
    assign busy         = busy_q;
    assign overrun      = ovr_q;

endmodule

// File: tb/tb_collision_engine.sv
// Self-checking bench: frame-level reference model plus directed and randomized frames.
module tb_collision_engine;

    localparam int NI = 10;
    localparam int NR = 3;
    localparam int NB = 4;
    localparam int TOTAL = NR * NI;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     frame_start;
    logic                     wave_reset;
    logic [NB-1:0][11:0]      bullet_x;
    logic [NB-1:0][11:0]      bullet_y;
    logic [NB-1:0]            bullet_active;
    logic [NI-1:0][11:0]      invader_x;
    logic [9:0]               enemy_ypos;
    logic [NR-1:0][NI-1:0]    alive;
    logic [NB-1:0]            bullet_hit;
    logic                     kill_valid;
    logic [1:0]               kill_row;
    logic [3:0]               kill_col;
    logic [15:0]              score;
    logic [4:0]               alive_count;
    logic                     wave_cleared;
    logic                     player_hit;
    logic                     busy;
    logic                     overrun;

    collision_engine dut (
        .clk(clk), .rst(rst), .frame_start(frame_start), .wave_reset(wave_reset),
        .bullet_x(bullet_x), .bullet_y(bullet_y), .bullet_active(bullet_active),
        .invader_x(invader_x), .enemy_ypos(enemy_ypos), .alive(alive),
        .bullet_hit(bullet_hit), .kill_valid(kill_valid), .kill_row(kill_row),
        .kill_col(kill_col), .score(score), .alive_count(alive_count),
        .wave_cleared(wave_cleared), .player_hit(player_hit), .busy(busy),
        .overrun(overrun)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err = 0;

    // Reference model state (frame-level: a whole scan's kills are planned at frame start).
    logic [NR-1:0][NI-1:0] m_alive;
    int                    m_count, m_score, m_pos, m_ypos, m_krow, m_kcol;
    bit                    m_ph, m_ovr, m_busy, m_kv;
    logic [NB-1:0]         m_bh;
    int                    plan_b[TOTAL];

    int                    kills_seen = 0;
    int                    last_krow, last_kcol;
    logic [NB-1:0]         last_bh;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic bit overlaps(input int bx, input int by, input int ix, input int iy);
        return (bx <= ix + 64) && (bx + 16 >= ix) && (by <= iy + 32) && (by + 32 >= iy);
    endfunction

    task automatic plan_frame();
        bit used[NB];
        logic [NR-1:0][NI-1:0] al;
        al = m_alive;
        m_ypos = int'(enemy_ypos);
        for (int b = 0; b < NB; b++) used[b] = 1'b0;
        for (int c = 0; c < TOTAL; c++) begin
            int r, col;
            r = c / NI;
            col = c % NI;
            plan_b[c] = -1;
            if (al[r][col]) begin
                for (int b = 0; b < NB; b++) begin
                    if (plan_b[c] < 0 && bullet_active[b] && !used[b] &&
                        overlaps(int'(bullet_x[b]), int'(bullet_y[b]),
                                 int'(invader_x[col]), m_ypos + r * 100)) begin
                        plan_b[c] = b;
                        used[b] = 1'b1;
                        al[r][col] = 1'b0;
                    end
                end
            end
        end
    endtask

    task automatic model_step();
        m_kv = 1'b0;
        m_bh = '0;
        if (rst) begin
            m_alive = '1; m_count = TOTAL; m_score = 0; m_ph = 0; m_ovr = 0;
            m_busy = 0; m_pos = 0;
        end else if (wave_reset) begin
            m_alive = '1; m_count = TOTAL; m_ph = 0; m_busy = 0; m_pos = 0;
        end else if (m_pos == 0) begin
            if (frame_start) begin
                plan_frame();
                m_pos = 1;
                m_busy = 1;
            end
        end else begin
            if (frame_start) m_ovr = 1;
            if (m_pos <= TOTAL) begin
                int c;
                c = m_pos - 1;
                if (plan_b[c] >= 0) begin
                    m_alive[c / NI][c % NI] = 1'b0;
                    m_count--;
                    m_score = m_score + 10 * (NR - c / NI);
                    if (m_score > 65535) m_score = 65535;
                    m_kv = 1; m_krow = c / NI; m_kcol = c % NI;
                    m_bh[plan_b[c]] = 1'b1;
                end
                m_pos++;
            end else begin
                for (int r = NR - 1; r >= 0; r--) begin
                    if (|m_alive[r]) begin
                        if (m_ypos + r * 100 + 32 >= 568) m_ph = 1;
                        break;
                    end
                end
                m_pos = 0;
                m_busy = 0;
            end
        end
    endtask

    // Model advances on each active edge; every output is compared on the following falling edge.
    initial begin
        forever begin
            @(posedge clk);
            model_step();
            @(negedge clk);
            chk("alive", alive, m_alive);
            chk("alive_count", alive_count, m_count);
            chk("score", score, m_score);
            chk("kill_valid", kill_valid, m_kv);
            chk("bullet_hit", bullet_hit, m_bh);
            if (m_kv) begin
                chk("kill_row", kill_row, m_krow);
                chk("kill_col", kill_col, m_kcol);
            end
            chk("wave_cleared", wave_cleared, m_count == 0);
            chk("player_hit", player_hit, m_ph);
            chk("busy", busy, m_busy);
            chk("overrun", overrun, m_ovr);
            if (kill_valid === 1'b1) begin
                kills_seen++;
                last_krow = int'(kill_row);
                last_kcol = int'(kill_col);
                last_bh = bullet_hit;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_frame();
        int n;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        n = 0;
        while (busy && n < 100) begin
            n++;
            tick();
        end
        chk("frame_done", busy, 1'b0);
    endtask

    task automatic pulse_wave_reset();
        wave_reset = 1'b1;
        tick();
        wave_reset = 1'b0;
    endtask

    initial begin
        int nb;
        rst = 1'b1; frame_start = 1'b0; wave_reset = 1'b0;
        bullet_x = '0; bullet_y = '0; bullet_active = '0; enemy_ypos = 10'd40;
        for (int c = 0; c < NI; c++) invader_x[c] = 12'(c * 200);
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk("reset_count", alive_count, 30);
        chk("reset_score", score, 0);

        // Single bullet kills (0,2).
        invader_x[2] = 12'd90;
        bullet_x[0] = 12'd100; bullet_y[0] = 12'd50; bullet_active = 4'b0001;
        kills_seen = 0;
        run_frame();
        chk("t1_score", score, 30);
        chk("t1_model_score", m_score, 30);
        chk("t1_count", alive_count, 29);
        chk("t1_cell", alive[0][2], 1'b0);
        chk("t1_kills", kills_seen, 1);
        chk("t1_bh", last_bh, 4'b0001);

        // Two bullets on the same cell: only bullet0 kills.
        invader_x[4] = 12'd400; invader_x[5] = 12'd470;
        bullet_x[0] = 12'd410; bullet_y[0] = 12'd150;
        bullet_x[1] = 12'd410; bullet_y[1] = 12'd150; bullet_active = 4'b0011;
        kills_seen = 0;
        run_frame();
        chk("t2_kills", kills_seen, 1);
        chk("t2_row", last_krow, 1);
        chk("t2_col", last_kcol, 4);
        chk("t2_bh", last_bh, 4'b0001);

        // One bullet overlapping (0,0) and (0,1): first scanned cell takes it.
        invader_x[0] = 12'd100; invader_x[1] = 12'd160;
        bullet_x[2] = 12'd158; bullet_y[2] = 12'd50; bullet_active = 4'b0100;
        kills_seen = 0;
        run_frame();
        chk("t3_kills", kills_seen, 1);
        chk("t3_col", last_kcol, 0);
        chk("t3_bh", last_bh, 4'b0100);

        // Invasion depth reached; stays sticky after kills in the bottom row.
        pulse_wave_reset();
        enemy_ypos = 10'd400; bullet_active = 4'b0000;
        run_frame();
        chk("t4_player_hit", player_hit, 1'b1);
        bullet_x[0] = 12'd610;  bullet_x[1] = 12'd480;
        bullet_x[2] = 12'd1210; bullet_x[3] = 12'd1410;
        for (int b = 0; b < NB; b++) bullet_y[b] = 12'd610;
        bullet_active = 4'b1111;
        kills_seen = 0;
        run_frame();
        chk("t4_kills", kills_seen, 4);
        chk("t4_sticky", player_hit, 1'b1);

        // Second frame_start mid-scan sets overrun; scan length is unaffected.
        pulse_wave_reset();
        enemy_ypos = 10'd40;
        bullet_x[0] = 12'd100; bullet_y[0] = 12'd50; bullet_active = 4'b0001;
        frame_start = 1'b1;
        tick();
        nb = 0;
        while (busy && nb < 100) begin
            frame_start = (nb == 4);
            nb++;
            tick();
        end
        frame_start = 1'b0;
        chk("t5_busy_len", nb, 31);
        chk("t5_overrun", overrun, 1'b1);
        chk("t5_score", score, 150);

        // wave_reset after three kills aborts the scan and keeps the score.
        pulse_wave_reset();
        invader_x[3] = 12'd600;
        bullet_x[0] = 12'd100; bullet_y[0] = 12'd50;
        bullet_x[1] = 12'd610; bullet_y[1] = 12'd50;
        bullet_x[2] = 12'd410; bullet_y[2] = 12'd50; bullet_active = 4'b0111;
        kills_seen = 0;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        repeat (8) tick();
        chk("t6_kills_before", kills_seen, 3);
        pulse_wave_reset();
        chk("t6_alive", alive, {TOTAL{1'b1}});
        chk("t6_score", score, 240);
        chk("t6_busy", busy, 1'b0);
        repeat (40) tick();
        chk("t6_kills_after", kills_seen, 3);

        // Randomized frames with mid-scan input churn, stray frame_starts and wave resets.
        for (int f = 0; f < 150; f++) begin
            int n, r;
            for (int c = 0; c < NI; c++) invader_x[c] = 12'(c * 90 + $urandom_range(0, 20));
            for (int b = 0; b < NB; b++) begin
                bullet_x[b] = 12'($urandom_range(0, 950));
                bullet_y[b] = 12'($urandom_range(0, 350));
            end
            bullet_active = 4'($urandom_range(0, 15));
            enemy_ypos = 10'($urandom_range(0, 400));
            if ($urandom_range(0, 9) == 0) pulse_wave_reset();
            frame_start = 1'b1;
            wave_reset = ($urandom_range(0, 15) == 0);
            tick();
            frame_start = 1'b0;
            wave_reset = 1'b0;
            n = 0;
            while (busy && n < 100) begin
                bullet_x[$urandom_range(0, NB - 1)] = 12'($urandom_range(0, 950));
                enemy_ypos = 10'($urandom_range(0, 1023));
                r = $urandom_range(0, 99);
                frame_start = (r < 3);
                wave_reset = (r == 50);
                n++;
                tick();
            end
            frame_start = 1'b0;
            wave_reset = 1'b0;
            chk("rand_frame_done", busy, 1'b0);
            repeat ($urandom_range(0, 3)) tick();
        end

        tick();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
